// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared constants for the multicycle MIPS main control FSM: opcodes,
//   state encodings, datapath select codes and the control-word struct
//   produced by mips_ctrl_outdec.
//   Optional feature macro: MIPS_CTRL_ADDI_EN (adds the addi opcode).
package mips_ctrl_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // State encodings
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;

    // ALU operand B select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // ALU operation
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Opcodes the FSM knows how to sequence; anything else is flagged illegal.
    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
             (op == OP_BEQ) || (op == OP_J);
`ifdef MIPS_CTRL_ADDI_EN
        ok = ok || (op == OP_ADDI);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec
//   Pure combinational Moore output decode: state -> datapath control word.
//   Ports:
//     state_i  in  STATE_W  current FSM state
//     stall_i  in  1        suppress write enables, keep selects/MemRead
//     rst_i    in  1        force the whole control word to 0
//     ctrl_o   out ctrl_t   decoded control word
//   Optional feature macro: MIPS_CTRL_ADDI_EN (decodes ADDIEX/ADDIWB).
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] state_i,
    input  logic               stall_i,
    input  logic               rst_i,
    output ctrl_t              ctrl_o
);

    ctrl_t c;

    always_comb begin
        c = '0;
        case (state_i)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: c.alu_src_b = SRCB_IMMSH2;   // precompute branch target
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: c.reg_write = 1'b1;
`endif
            default: c = '0;
        endcase

        // A held state must not repeat its architectural side effects.
        if (stall_i) begin
            c.reg_write     = 1'b0;
            c.mem_write     = 1'b0;
            c.ir_write      = 1'b0;
            c.pc_write      = 1'b0;
            c.pc_write_cond = 1'b0;
        end

        // Reset kills everything, including the cycle it is asserted in.
        if (rst_i) c = '0;

        ctrl_o = c;
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Main control FSM of the 32-bit multicycle MIPS datapath (Moore).
//   Holds the state register and next-state logic; output decode lives in
//   mips_ctrl_outdec.
//   Ports:
//     Clk, Rst (sync, active high), Op (IR opcode), Stall (hold state,
//     suppress writes); outputs RegDst, MemtoReg, RegWrite, IorD, MemRead,
//     MemWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA, ALUSrcB, ALUOp,
//     PCSource, IllegalOp (DECODE of unsupported opcode), State (debug).
//   Optional feature macro: MIPS_CTRL_ADDI_EN (addi via ADDIEX/ADDIWB).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [OP_W-1:0]    Op,
    input  logic               Stall,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] State
);

    logic [STATE_W-1:0] state_q, state_d;
    ctrl_t              ctrl;

    always_comb begin
        state_d = state_q;
        if (!Stall) begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                        OP_ADDI:      state_d = S_ADDIEX;
`endif
                        default:      state_d = S_FETCH;
                    endcase
                end
                S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_d = S_MEMWB;
                S_EXEC:   state_d = S_ALUWB;
`ifdef MIPS_CTRL_ADDI_EN
                S_ADDIEX: state_d = S_ADDIWB;
`endif
                // MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB and any
                // unused encoding all fall back to FETCH.
                default:  state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    mips_ctrl_outdec #(.STATE_W(STATE_W)) u_outdec (
        .state_i (state_q),
        .stall_i (Stall),
        .rst_i   (Rst),
        .ctrl_o  (ctrl)
    );

    assign RegDst      = ctrl.reg_dst;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegWrite    = ctrl.reg_write;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;

    // Masked during Stall so a held DECODE still yields a single pulse,
    // on the cycle that actually leaves DECODE.
    assign IllegalOp = !Rst && !Stall && (state_q == S_DECODE) && !op_supported(Op);

    // Reset forces every output to 0, the debug state included.
    assign State = Rst ? '0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Directed-vector bench for mips_multicycle_ctrl: reset, every instruction
//   class, illegal opcode, stall holds and a mid-instruction reset.
//   Honors MIPS_CTRL_ADDI_EN for the addi expectations.
module tb_mips_multicycle_ctrl;

    logic       Clk = 1'b0;
    logic       Rst, Stall;
    logic [5:0] Op;
    logic       RegDst, MemtoReg, RegWrite, IorD, MemRead, MemWrite, IRWrite;
    logic       PCWrite, PCWriteCond, ALUSrcA, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    mips_multicycle_ctrl #(.OP_W(6), .STATE_W(4)) dut (
        .Clk(Clk), .Rst(Rst), .Op(Op), .Stall(Stall),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .IllegalOp(IllegalOp), .State(State)
    );

    logic [16:0] outs;
    assign outs = {RegDst, MemtoReg, RegWrite, IorD, MemRead, MemWrite, IRWrite, PCWrite,
                   PCWriteCond, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
`ifdef MIPS_CTRL_ADDI_EN
        return op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08};
`else
        return op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h02};
`endif
    endfunction

    // Expected control word per state, straight from the output table.
    function automatic logic [16:0] exp_out(input int st, input logic [5:0] op, input bit stall);
        logic rd, m2r, rw, iord, mr, mw, irw, pcw, pcwc, sa, ill;
        logic [1:0] sb, aop, pcs;
        {rd, m2r, rw, iord, mr, mw, irw, pcw, pcwc, sa, ill} = '0;
        sb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin mr = 1; irw = 1; pcw = 1; sb = 2'b01; end
            1:  begin sb = 2'b11; ill = !legal(op); end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin sa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin sa = 1; sb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        if (stall) begin
            rw = 0; mw = 0; irw = 0; pcw = 0; pcwc = 0; ill = 0;
        end
        return {rd, m2r, rw, iord, mr, mw, irw, pcw, pcwc, sa, sb, aop, pcs, ill};
    endfunction

    // One clock: sample mid-cycle, then advance just past the next edge.
    task automatic cyc(input string tag, input int st, input bit stall);
        @(negedge Clk);
        chk($sformatf("%s st%0d state", tag, st), {28'd0, State}, st);
        chk($sformatf("%s st%0d ctrl", tag, st), {15'd0, outs}, {15'd0, exp_out(st, Op, stall)});
        @(posedge Clk); #1;
    endtask

    task automatic rst_cyc(input string tag);
        @(negedge Clk);
        chk({tag, " state"}, {28'd0, State}, 32'd0);
        chk({tag, " ctrl"}, {15'd0, outs}, 32'd0);
        @(posedge Clk); #1;
    endtask

    task automatic run_seq(input string tag, input logic [5:0] op, input int n,
                           input int s0, input int s1, input int s2, input int s3, input int s4);
        int s[5];
        s = '{s0, s1, s2, s3, s4};
        Op = op;
        for (int i = 0; i < n; i++) cyc(tag, s[i], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Rst = 1'b1; Stall = 1'b0; Op = 6'h23;
        rst_cyc("reset0");
        rst_cyc("reset1");
        Rst = 1'b0;

        run_seq("lw",    6'h23, 5, 0, 1, 2, 3, 4);
        run_seq("rtype", 6'h00, 4, 0, 1, 6, 7, 0);
        run_seq("sw",    6'h2B, 4, 0, 1, 2, 5, 0);
        run_seq("beq",   6'h04, 3, 0, 1, 8, 0, 0);
        run_seq("j",     6'h02, 3, 0, 1, 9, 0, 0);
        run_seq("ill3f", 6'h3F, 2, 0, 1, 0, 0, 0);
`ifdef MIPS_CTRL_ADDI_EN
        run_seq("addi",  6'h08, 4, 0, 1, 10, 11, 0);
`else
        run_seq("op08",  6'h08, 2, 0, 1, 0, 0, 0);
`endif

        // Stall in FETCH for 3 cycles, release, then stall in ALUWB.
        Op = 6'h00; Stall = 1'b1;
        for (int i = 0; i < 3; i++) cyc("stall_fetch", 0, 1'b1);
        Stall = 1'b0;
        cyc("release_fetch", 0, 1'b0);
        cyc("release_fetch", 1, 1'b0);
        cyc("rtype_s", 6, 1'b0);
        Stall = 1'b1;
        for (int i = 0; i < 2; i++) cyc("stall_aluwb", 7, 1'b1);
        Stall = 1'b0;
        cyc("release_aluwb", 7, 1'b0);

        // Reset while in MEMWR aborts the store.
        Op = 6'h2B;
        cyc("sw_pre", 0, 1'b0);
        cyc("sw_pre", 1, 1'b0);
        cyc("sw_pre", 2, 1'b0);
        Rst = 1'b1;
        rst_cyc("rst_memwr");
        Rst = 1'b0;
        run_seq("sw_post", 6'h2B, 4, 0, 1, 2, 5, 0);
        cyc("final", 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
